uart_tx_arbiter: RTL

//  Shares the single UART transmitter among NREQ byte requesters using round-robin arbitration.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_rr_picker.sv | 30 +++
 rtl/uart_tx_arbiter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_pkg;

    localparam int TMO_W       = 16;
    localparam int ARB_MAX_REQ = 8;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_SEND = 2'd1,
        ARB_DONE = 2'd2
    } arb_state_t;

    // Index of the requester 'off' places after 'base', wrapping at n.
    function automatic int rr_wrap(input int base, input int off, input int n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin select: first valid requester after the pointer.
module uart_rr_picker
    import uart_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req_valid,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] grant_idx
);

    logic found;

    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!found && req_valid[rr_wrap(int'(ptr), k, NREQ)]) begin
                found                                = 1'b1;
                grant[rr_wrap(int'(ptr), k, NREQ)]   = 1'b1;
                grant_idx = IDX_W'(rr_wrap(int'(ptr), k, NREQ));
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter; one frame in flight at a time.
// Optional SEND watchdog enabled by defining UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int SYNC_STG = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    arb_en,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*8-1:0]       req_data,
    output logic [NREQ-1:0]         req_ready,
    output logic [NREQ-1:0]         req_done,
    output logic [$clog2(NREQ)-1:0] owner,
    output logic                    busy,
    input  logic [TMO_W-1:0]        timeout_cycles,
    output logic                    timeout_err,
    output logic [7:0]              uart_din,
    output logic                    uart_tx_en,
    output logic                    uart_bclk_en,
    input  logic                    uart_tx_done,
    input  logic                    uart_br_cfg_err
);

    localparam int IDX_W = $clog2(NREQ);

    arb_state_t          state;
    logic [IDX_W-1:0]    ptr;
    logic [NREQ-1:0]     grant;
    logic [IDX_W-1:0]    grant_idx;
    logic [SYNC_STG-1:0] done_sync;
    logic                done_prev;
    logic                done_rise;
    logic                start;
    logic                tmo_fire;

    uart_rr_picker #(.NREQ(NREQ), .IDX_W(IDX_W)) u_picker (
        .req_valid (req_valid),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign start     = arb_en & ~uart_br_cfg_err & (|req_valid);
    assign busy      = (state != ARB_IDLE);
    assign req_ready = (!rst && state == ARB_IDLE && start) ? grant : '0;
    assign req_done  = (state == ARB_DONE) ? (NREQ'(1) << owner) : '0;
    assign done_rise = done_sync[SYNC_STG-1] & ~done_prev;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_sync <= '0;
            done_prev <= 1'b0;
        end else begin
            done_sync <= {done_sync[SYNC_STG-2:0], uart_tx_done};
            done_prev <= done_sync[SYNC_STG-1];
        end
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    logic [TMO_W-1:0] wdog;

    // Counts SEND cycles from 0; fires on the edge that ends SEND cycle timeout_cycles.
    assign tmo_fire = (state == ARB_SEND) && !done_rise &&
                      (timeout_cycles != '0) && (wdog == timeout_cycles);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog        <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= tmo_fire;
            if (state != ARB_SEND)
                wdog <= '0;
            else if (wdog != '1)
                wdog <= wdog + 1'b1;
        end
    end
`else
    logic unused_tmo;

    assign unused_tmo  = ^timeout_cycles;
    assign tmo_fire    = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ARB_IDLE;
            uart_din     <= '0;
            uart_tx_en   <= 1'b0;
            uart_bclk_en <= 1'b0;
            owner        <= '0;
            ptr          <= IDX_W'(NREQ - 1);
        end else begin
            uart_bclk_en <= arb_en;
            case (state)
                ARB_IDLE: begin
                    if (start) begin
                        uart_din   <= req_data[8*grant_idx +: 8];
                        owner      <= grant_idx;
                        ptr        <= grant_idx;
                        uart_tx_en <= 1'b1;
                        state      <= ARB_SEND;
                    end
                end
                ARB_SEND: begin
                    // A completion seen in the same cycle as the watchdog takes priority.
                    if (done_rise) begin
                        uart_tx_en <= 1'b0;
                        state      <= ARB_DONE;
                    end else if (tmo_fire) begin
                        uart_tx_en <= 1'b0;
                        state      <= ARB_IDLE;
                    end
                end
                ARB_DONE: state <= ARB_IDLE;
                default:  state <= ARB_IDLE;
            endcase
        end
    end

endmodule
